// File: rtl/pix_shift_pkg.sv
// Shared constants and types for the pixel shifter.
//   PLANES_DEF / WIDTH_DEF : default bitplane count and pixels per word
//   CNT_W_DEF              : width of the pixels-remaining counter at the defaults
//   plane_word_t           : packed plane word at the defaults (plane p = [p*W +: W])
//   cnt_width()            : counter width needed to hold 0..w
package pix_shift_pkg;

  localparam int unsigned PLANES_DEF = 2;
  localparam int unsigned WIDTH_DEF  = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef logic [PLANES_DEF*WIDTH_DEF-1:0] plane_word_t;

endpackage

// File: rtl/pix_plane_shreg.sv
// One bitplane shifter.
//   clk, res : clock, synchronous active-high reset
//   load     : take ld_data (flipped/pre-shifted) as the new word
//   shift    : advance to the next pixel of the stored word
//   ld_data  : plane word from the hold register
//   ld_flip  : 1 = emit bit 0 first
//   ld_skip  : leading pixels to discard on load
//   pix      : pixel emitted this cycle (load source when loading, else shifter head)
// The word is normalised to MSB-first on load, so the stored register always
// shifts left regardless of flip.
module pix_plane_shreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SKW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_flip,
  input  logic [SKW-1:0]   ld_skip,
  output logic             pix
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] ld_norm;
  logic [WIDTH-1:0] ld_pre;

  always_comb begin
    ld_norm = ld_data;
    if (ld_flip) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        ld_norm[i] = ld_data[WIDTH-1-i];
      end
    end
    ld_pre = ld_norm << ld_skip;
    pix    = load ? ld_pre[WIDTH-1] : sr[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sr <= '0;
    end else if (load) begin
      // head pixel leaves on this same edge
      sr <= ld_pre << 1;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

endmodule

// File: rtl/pix_shift_ser.sv
// Double-buffered parallel-in / serial-out pixel shifter.
//   clk, res   : clock, synchronous active-high reset
//   cen        : pixel clock enable, one pixel per cen cycle
//   d, d_valid : packed plane words (plane p = d[p*WIDTH +: WIDTH]) and valid
//   d_ready    : registered, high while the hold register is empty
//   flip       : horizontal flip, captured with the word
//   skip       : fine-scroll pre-skip, only with PIX_SHIFT_FINE_SCROLL_EN defined
//   pix_out    : current pixel, bit p from plane p
//   pix_valid  : pix_out carries real data
//   underrun   : one-clk pulse on the first starved cen after valid pixels
module pix_shift_ser
  import pix_shift_pkg::*;
#(
  parameter int unsigned PLANES = PLANES_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      cen,
  input  logic [PLANES*WIDTH-1:0]   d,
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic                      flip,
`ifdef PIX_SHIFT_FINE_SCROLL_EN
  input  logic [$clog2(WIDTH)-1:0]  skip,
`endif
  output logic [PLANES-1:0]         pix_out,
  output logic                      pix_valid,
  output logic                      underrun
);

  localparam int unsigned CW  = cnt_width(WIDTH);
  localparam int unsigned SKW = $clog2(WIDTH);

  logic [PLANES*WIDTH-1:0] hold_d;
  logic                    hold_flip;
  logic [SKW-1:0]          hold_skip;
  logic                    hold_full;
  logic [CW-1:0]           cnt;
  logic [SKW-1:0]          skip_in;

  logic                    accept;
  logic                    from_sh;
  logic                    from_hold;
  logic                    hold_full_n;
  logic [PLANES-1:0]       next_pix;

`ifdef PIX_SHIFT_FINE_SCROLL_EN
  assign skip_in = skip;
`else
  assign skip_in = '0;
`endif

  always_comb begin
    accept    = d_valid && d_ready;
    from_sh   = cen && (cnt != '0);
    from_hold = cen && (cnt == '0) && hold_full;
    // accept only happens with hold empty, so it never overlaps from_hold
    hold_full_n = hold_full;
    if (from_hold) hold_full_n = 1'b0;
    if (accept)    hold_full_n = 1'b1;
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    pix_plane_shreg #(
      .WIDTH (WIDTH),
      .SKW   (SKW)
    ) u_plane (
      .clk     (clk),
      .res     (res),
      .load    (from_hold),
      .shift   (from_sh),
      .ld_data (hold_d[p*WIDTH +: WIDTH]),
      .ld_flip (hold_flip),
      .ld_skip (hold_skip),
      .pix     (next_pix[p])
    );
  end

  always_ff @(posedge clk) begin
    if (res) begin
      hold_d    <= '0;
      hold_flip <= 1'b0;
      hold_skip <= '0;
      hold_full <= 1'b0;
      d_ready   <= 1'b1;
      cnt       <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        hold_d    <= d;
        hold_flip <= flip;
        hold_skip <= skip_in;
      end
      hold_full <= hold_full_n;
      d_ready   <= !hold_full_n;

      underrun <= 1'b0;
      if (cen) begin
        if (from_sh || from_hold) begin
          pix_out   <= next_pix;
          pix_valid <= 1'b1;
          cnt       <= from_sh ? cnt - 1'b1 : CW'(WIDTH - 1) - CW'(hold_skip);
        end else begin
          pix_out   <= '0;
          pix_valid <= 1'b0;
          underrun  <= pix_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_pix_shift_ser.sv
module tb_pix_shift_ser;
  import pix_shift_pkg::*;

  localparam int unsigned P = 2;
  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        res, cen, d_valid, flip;
  plane_word_t d;
  logic [2:0]  skip;
  logic        d_ready, pix_valid, underrun;
  logic [1:0]  pix_out;

  always #5 clk = ~clk;

  pix_shift_ser #(.PLANES(P), .WIDTH(W)) dut (
    .clk       (clk),
    .res       (res),
    .cen       (cen),
    .d         (d),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .flip      (flip),
`ifdef PIX_SHIFT_FINE_SCROLL_EN
    .skip      (skip),
`endif
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .underrun  (underrun)
  );

  // ---------------- behavioural model (queues of pixels) ----------------
  logic [1:0] shq[$];
  logic [1:0] cap[$];
  logic [15:0] m_hold_word;
  logic       m_hold_flip;
  int         m_hold_skip;
  bit         m_hold_full;
  logic [1:0] m_pix;
  bit         m_val, m_und, m_ready, m_acc, m_last_cen;

  int n_chk = 0, n_fail = 0;
  int run = 0, max_run = 0, und_cnt = 0;

  task automatic model_step();
    bit acc;
    logic [1:0] lst[$];
    int b;
    m_last_cen = cen;
    m_acc = 1'b0;
    if (res) begin
      m_hold_full = 0; shq.delete();
      m_pix = 2'b00; m_val = 0; m_und = 0; m_ready = 1;
      return;
    end
    acc = d_valid && m_ready;
    m_und = 0;
    if (cen) begin
      if (shq.size() > 0) begin
        m_pix = shq.pop_front(); m_val = 1;
      end else if (m_hold_full) begin
        for (int i = 0; i < int'(W); i++) begin
          b = m_hold_flip ? i : int'(W) - 1 - i;
          lst.push_back({m_hold_word[W + b], m_hold_word[b]});
        end
        for (int i = 0; i < m_hold_skip; i++) void'(lst.pop_front());
        m_pix = lst.pop_front();
        shq = lst;
        m_hold_full = 0; m_val = 1;
      end else begin
        m_und = m_val; m_pix = 2'b00; m_val = 0;
      end
    end
    if (acc) begin
      m_hold_word = d; m_hold_flip = flip; m_hold_full = 1; m_acc = 1;
`ifdef PIX_SHIFT_FINE_SCROLL_EN
      m_hold_skip = int'(skip);
`else
      m_hold_skip = 0;
`endif
    end
    m_ready = !m_hold_full;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("pix_out",   32'(pix_out),   32'(m_pix));
    check("pix_valid", 32'(pix_valid), 32'(m_val));
    check("underrun",  32'(underrun),  32'(m_und));
    check("d_ready",   32'(d_ready),   32'(m_ready));
    if (m_last_cen && pix_valid === 1'b1) cap.push_back(pix_out);
    if (pix_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (underrun === 1'b1) und_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_stats();
    cap.delete(); run = 0; max_run = 0; und_cnt = 0;
  endtask

  logic [1:0] exp_basic[8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
  logic [1:0] exp_flip[8]  = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
  logic [1:0] exp_sparse[8] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  plane_word_t words[3] = '{16'h0FA5, 16'h3C81, 16'hF0AA};

  initial begin
    int idx;
    res = 1; cen = 0; d = '0; d_valid = 0; flip = 0; skip = '0;
    m_hold_skip = 0; m_hold_word = '0; m_hold_flip = 0;
    tick(); tick();
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_d_ready",   32'(d_ready),   32'd1);
    res = 0;

    // reset mid-word
    d = 16'hF0AA; d_valid = 1; tick();
    d_valid = 0; cen = 1;
    repeat (3) tick();
    res = 1; tick(); res = 0;
    check("midreset_pix_out",   32'(pix_out),   32'd0);
    check("midreset_pix_valid", 32'(pix_valid), 32'd0);
    check("midreset_d_ready",   32'(d_ready),   32'd1);
    clear_stats();
    repeat (10) tick();
    check("midreset_no_pixels", 32'(cap.size()), 32'd0);

    // basic MSB-first, then flip
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      d = 16'h0FA5; flip = f[0]; d_valid = 1; cen = 1; tick();
      d_valid = 0;
      repeat (12) tick();
      check(f ? "flip_count" : "basic_count", 32'(cap.size()), 32'd8);
      for (int i = 0; i < 8 && i < cap.size(); i++)
        check(f ? "flip_pix" : "basic_pix", 32'(cap[i]), f ? 32'(exp_flip[i]) : 32'(exp_basic[i]));
      check(f ? "flip_underrun" : "basic_underrun", 32'(und_cnt), 32'd1);
    end
    flip = 0;

    // back-to-back with backpressure
    clear_stats();
    idx = 0; d = words[0]; d_valid = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m_acc) begin
        idx++;
        if (idx < 3) d = words[idx]; else d_valid = 0;
      end
    end
    check("b2b_words_taken", 32'(idx), 32'd3);
    check("b2b_run", 32'(max_run), 32'd24);
    check("b2b_underrun", 32'(und_cnt), 32'd1);

    // sparse cen
    clear_stats();
    d = 16'h3C81; d_valid = 1;
    for (int c = 0; c < 48; c++) begin
      cen = (c % 4 == 0);
      tick();
      d_valid = 0;
    end
    check("sparse_count", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      check("sparse_pix", 32'(cap[i]), 32'(exp_sparse[i]));
    check("sparse_valid_clks", 32'(max_run), 32'd32);
    check("sparse_underrun", 32'(und_cnt), 32'd1);
    cen = 1;

`ifdef PIX_SHIFT_FINE_SCROLL_EN
    // fine scroll: skip 3 of plane0=0xA5, then 0x80 with no skip
    clear_stats();
    d = 16'h00A5; skip = 3'd3; d_valid = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_acc) begin d = 16'h0080; skip = 3'd0; end
      if (c > 2) d_valid = 0;
    end
    check("scroll_run", 32'(max_run), 32'd13);
    if (cap.size() >= 6) begin
      check("scroll_p0", 32'(cap[0][0]), 32'd0);
      check("scroll_p1", 32'(cap[1][0]), 32'd0);
      check("scroll_p2", 32'(cap[2][0]), 32'd1);
      check("scroll_p3", 32'(cap[3][0]), 32'd0);
      check("scroll_p4", 32'(cap[4][0]), 32'd1);
      check("scroll_next", 32'(cap[5][0]), 32'd1);
    end else check("scroll_count", 32'(cap.size()), 32'd13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pix_shift_ser.md
Name: pix_shift_ser

Overview:
- Parallel-in, serial-out pixel shifter for tile and sprite graphics.
- Sits directly downstream of the 8-bit graphics data latch. Consumes latched ROM bitplane words and emits one multi-plane pixel per pixel-clock enable.
- Double-buffered (hold register plus shifter), so back-to-back words stream without gaps.
- Replaces the 74LS166/74LS194 shifter chain of the original boards.

Parameters:
- PLANES, 2, number of bitplanes; one shifter per plane.
- WIDTH, 8, pixels per word; must be ≥2.

Ports:
- clk  in  1  system clock.
- res  in  1  reset. Synchronous, active-high.
- cen  in  1  pixel clock enable; one pixel per cen cycle.
- d  in  PLANES*WIDTH  packed plane words; plane p is d[p*WIDTH +: WIDTH].
- d_valid  in  1  upstream word present.
- d_ready  out  1  hold register empty.
- flip  in  1  horizontal flip, sampled with the word.
- pix_out  out  PLANES  current pixel; bit p comes from plane p.
- pix_valid  out  1  pix_out carries real data.
- underrun  out  1  one-cycle pulse when the pixel stream starves.

Behaviour:
- Reset values on res=1 at a clk edge:
  - pix_out=0, pix_valid=0, underrun=0, d_ready=1.
  - hold empty; shifter count cnt=0.
  - res takes priority over every other input, including mid-word: partially shifted data is discarded.
- Accept rule:
  - A word is accepted when d_valid && d_ready at a clk edge.
  - d and flip are captured into hold; hold_full is set.
  - Acceptance is independent of cen.
- d_ready = !hold_full, registered. There is no bypass: if hold is consumed in a cycle, d_ready rises only on the next cycle.
- cnt has $clog2(WIDTH+1) bits and counts pixels remaining in the shifter.
- On each cen cycle, the source is the shifter if cnt≠0; otherwise it is hold if hold_full.
  - Source exists:
    - Emit the next pixel of the source into pix_out; set pix_valid=1.
    - Shift the source into the shifter.
    - cnt becomes cnt−1 if the source was the shifter, else WIDTH−1.
    - If the source was hold, clear hold_full.
    - Latency: the first pixel appears on the cen edge at which the word enters the shifter.
  - No source:
    - pix_out=0, pix_valid=0.
    - underrun=1 for one clk if pix_valid was 1 on the previous cen; otherwise underrun=0.
- Pixel order:
  - flip=0: bit WIDTH−1 first (MSB-first).
  - flip=1: bit 0 first.
  - Flip applies to all planes of that word and is latched with it, never taken live.
- Non-cen cycles: pix_out, pix_valid and cnt hold their values; underrun=0.
- Simultaneous accept and hold→shifter transfer in one cycle: the transfer uses the old hold contents, and the new word is not accepted (d_ready was 0).
- Word boundary at cnt=1: the last pixel is emitted. On the next cen, the shifter is empty and hold is used, so there is no gap if hold_full.

Optional Feature:
- Macro: PIX_SHIFT_FINE_SCROLL_EN.
- With the macro defined:
  - Adds input port skip, width $clog2(WIDTH), captured into hold with each accepted word.
  - On a hold→shifter transfer, the first skip pixels in the current flip order are discarded, with no cycle cost.
  - The emitted pixel is pixel index skip; cnt is loaded with WIDTH−1−skip.
- Without the macro: the port is absent and skip is treated as 0; behaviour is identical to the base block.

Decomposition:
- Package pix_shift_pkg:
  - Default PLANES and WIDTH constants.
  - Count-width constant.
  - Typedef for the packed plane word.
- Sub-module pix_plane_shreg, one instance per plane:
  - WIDTH-bit shift register with load, direction (flip) and pre-shift amount.
  - The top level owns the hold register, cnt, handshake and underrun logic.

Test Plan:
- Reset mid-word:
  - Stimulus: load d=16'hF0_AA, run 3 cen, assert res for 1 clk.
  - Response: pix_out=0, pix_valid=0, d_ready=1, and no further pixels without a new word.
- Basic MSB-first:
  - Stimulus: d=16'h0F_A5 (plane1=0x0F, plane0=0xA5), flip=0, cen every cycle.
  - Response: pix_out sequence 2'b01,00,01,00,10,11,10,11, then pix_valid=0 and one underrun pulse.
- Flip:
  - Stimulus: same word with flip=1.
  - Response: sequence 2'b11,10,11,10,00,01,00,01.
- Back-to-back and backpressure:
  - Stimulus: hold d_valid=1 with three words; cen every cycle.
  - Response:
    - 24 consecutive pix_valid=1 cycles with no gap.
    - d_ready low while hold is full.
    - No underrun until after pixel 24.
- Sparse cen:
  - Stimulus: cen every 4th clk.
  - Response: each pixel is held for 4 clks; total of 8 cen per word; underrun only on the first starved cen.
- Fine scroll (PIX_SHIFT_FINE_SCROLL_EN only):
  - Stimulus: skip=3, plane0=0xA5, flip=0.
  - Response: plane0 bits 0,0,1,0,1, then the next word starts immediately.
